// File: rtl/alu4_seq.sv
// Nibble-serial sequencer driving a shared 4-bit alu4 slice.
// Wide operands are processed LSB nibble first, with carry chained between nibbles.
module alu4_seq #(
  parameter int WIDTH   = 4,
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [WIDTH*NIBBLES-1:0]   in_a,
  input  logic [WIDTH*NIBBLES-1:0]   in_b,
  input  logic                       in_b_inv,
  input  logic                       in_cin,
  input  logic [1:0]                 in_op,
  input  logic                       abort,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH*NIBBLES-1:0]   res_s,
  output logic                       res_c,
  output logic                       res_zero,
  output logic                       res_overflow,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic                       alu_b_inv,
  output logic                       alu_y,
  output logic [1:0]                 alu_op,
  input  logic [WIDTH-1:0]           alu_s,
  input  logic                       alu_c,
  input  logic                       alu_zero,
  input  logic                       alu_overflow
);

  localparam int OPW  = WIDTH * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [IDXW-1:0]  idx;
  logic [OPW-1:0]   a_reg;
  logic [OPW-1:0]   b_reg;
  logic             b_inv_reg;
  logic [1:0]       op_reg;
  logic             carry;
  logic             zero_acc;
  logic [OPW-1:0]   work;
  logic [OPW-1:0]   work_next;
  logic             accept;
  logic             last_nibble;

  assign accept      = (state == IDLE) && req_valid && !abort;
  assign last_nibble = (idx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort outranks both completion and the result handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid && !abort) next_state = RUN;
      RUN: begin
        if (abort)            next_state = IDLE;
        else if (last_nibble) next_state = DONE;
      end
      DONE: if (abort || res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    res_valid = (state == DONE);
    alu_a     = '0;
    alu_b     = '0;
    alu_b_inv = 1'b0;
    alu_y     = 1'b0;
    alu_op    = 2'b00;
    if (state == RUN) begin
      alu_a     = a_reg[int'(idx)*WIDTH +: WIDTH];
      alu_b     = b_reg[int'(idx)*WIDTH +: WIDTH];
      alu_b_inv = b_inv_reg;
      alu_y     = carry;
      alu_op    = op_reg;
    end
  end

  // Partial result with the current nibble merged in; committed to res_s only on completion.
  always_comb begin
    work_next = work;
    work_next[int'(idx)*WIDTH +: WIDTH] = alu_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      b_inv_reg    <= 1'b0;
      op_reg       <= 2'b00;
      carry        <= 1'b0;
      zero_acc     <= 1'b0;
      work         <= '0;
      res_s        <= '0;
      res_c        <= 1'b0;
      res_zero     <= 1'b0;
      res_overflow <= 1'b0;
    end else if (accept) begin
      a_reg     <= in_a;
      b_reg     <= in_b;
      b_inv_reg <= in_b_inv;
      op_reg    <= in_op;
      carry     <= in_cin;
      idx       <= '0;
      zero_acc  <= 1'b1;
      work      <= '0;
    end else if (state == RUN && !abort) begin
      work     <= work_next;
      carry    <= alu_c;
      zero_acc <= zero_acc & alu_zero;
      if (last_nibble) begin
        res_s        <= work_next;
        res_c        <= alu_c;
        res_zero     <= zero_acc & alu_zero;
        res_overflow <= alu_overflow;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu4_seq.sv
// Scoreboard bench for alu4_seq with a behavioural alu4 slice closing the loop.
module tb_alu4_seq;

  localparam int WIDTH   = 4;
  localparam int NIBBLES = 4;
  localparam int OPW     = WIDTH * NIBBLES;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [OPW-1:0]   in_a;
  logic [OPW-1:0]   in_b;
  logic             in_b_inv;
  logic             in_cin;
  logic [1:0]       in_op;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [OPW-1:0]   res_s;
  logic             res_c;
  logic             res_zero;
  logic             res_overflow;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_b_inv;
  logic             alu_y;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_s;
  logic             alu_c;
  logic             alu_zero;
  logic             alu_overflow;

  typedef struct packed {
    logic [OPW-1:0] s;
    logic           c;
    logic           z;
    logic           v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid;
  logic [3:0] y_seen;
  logic [1:0] op_seen [4];

  alu4_seq #(.WIDTH(WIDTH), .NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .in_a(in_a), .in_b(in_b), .in_b_inv(in_b_inv), .in_cin(in_cin), .in_op(in_op),
    .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_s(res_s), .res_c(res_c), .res_zero(res_zero), .res_overflow(res_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_b_inv(alu_b_inv), .alu_y(alu_y), .alu_op(alu_op),
    .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alu4 slice: op 00 add, 01 and, 10 or, 11 xor; flags only meaningful for add.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] bb;
  always_comb begin
    bb           = alu_b ^ {WIDTH{alu_b_inv}};
    sum          = {1'b0, alu_a} + {1'b0, bb} + {{WIDTH{1'b0}}, alu_y};
    alu_s        = sum[WIDTH-1:0];
    alu_c        = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_s        = sum[WIDTH-1:0];
        alu_c        = sum[WIDTH];
        alu_overflow = (alu_a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      2'b01: alu_s = alu_a & bb;
      2'b10: alu_s = alu_a | bb;
      default: alu_s = alu_a ^ bb;
    endcase
    alu_zero = (alu_s == '0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation on every rising edge of res_valid.
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (res_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_s", res_s, e.s);
          checkOutput("res_c", res_c, e.c);
          checkOutput("res_zero", res_zero, e.z);
          checkOutput("res_overflow", res_overflow, e.v);
        end
      end
      prev_valid <= res_valid;
    end
  end

  task automatic applyStimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                               input logic inv, input logic cin, input logic [1:0] op,
                               input logic [OPW-1:0] es, input logic ec, input logic ez,
                               input logic ev, input int hold, input bit req_in_hold,
                               input bit release_done);
    int lat;
    @(negedge clk);
    checkOutput("req_ready_idle", req_ready, 1);
    in_a = a; in_b = b; in_b_inv = inv; in_cin = cin; in_op = op;
    req_valid = 1'b1;
    exp_q.push_back('{s: es, c: ec, z: ez, v: ev});
    @(posedge clk);
    #1 req_valid = 1'b0;
    in_a = '0; in_b = '0; in_b_inv = 1'b0; in_cin = 1'b0; in_op = 2'b00;
    lat = 0;
    y_seen = '0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat <= NIBBLES) begin
        y_seen[lat-1]    = alu_y;
        op_seen[lat-1]   = alu_op;
      end
    end
    checkOutput("latency", lat, NIBBLES + 1);
    if (!res_valid) return;
    for (int i = 0; i < hold; i++) begin
      if (req_in_hold) begin
        req_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
      end
      @(negedge clk);
      checkOutput("hold_valid", res_valid, 1);
      checkOutput("hold_req_ready", req_ready, 0);
      checkOutput("hold_res_s", res_s, es);
      checkOutput("hold_res_c", res_c, ec);
      checkOutput("hold_res_zero", res_zero, ez);
    end
    req_valid = 1'b0; in_a = '0; in_b = '0;
    if (release_done) begin
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      checkOutput("release_req_ready", req_ready, 1);
      checkOutput("release_res_valid", res_valid, 0);
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; req_valid = 1'b0; in_a = '0; in_b = '0; in_b_inv = 1'b0;
    in_cin = 1'b0; in_op = 2'b00; abort = 1'b0; res_ready = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_s", res_s, 0);
    checkOutput("rst_flags", {res_c, res_zero, res_overflow}, 0);
    checkOutput("rst_alu_out", {alu_a, alu_b, alu_b_inv, alu_y, alu_op}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Carry rippling across two nibbles; alu_y sequence 0,1,1,0.
    applyStimulus(16'h00FF, 16'h0001, 0, 0, 2'b00, 16'h0100, 0, 0, 0, 0, 0, 1);
    checkOutput("t1_alu_y_seq", y_seen, 4'b0110);
    // Subtract equal operands.
    applyStimulus(16'h1234, 16'h1234, 1, 1, 2'b00, 16'h0000, 1, 1, 0, 0, 0, 1);
    // Signed overflow on the top nibble.
    applyStimulus(16'h7FFF, 16'h0001, 0, 0, 2'b00, 16'h8000, 0, 0, 1, 0, 0, 1);
    // Borrow out of a subtract.
    applyStimulus(16'h0000, 16'h0001, 1, 1, 2'b00, 16'hFFFF, 0, 0, 0, 0, 0, 1);
    // Backpressure with a competing request.
    applyStimulus(16'hFFFF, 16'h0001, 0, 0, 2'b00, 16'h0000, 1, 1, 0, 6, 1, 1);
    // Logic ops pass op through unchanged.
    applyStimulus(16'hF0F0, 16'h0FF0, 0, 0, 2'b11, 16'hFF00, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NIBBLES; i++) checkOutput("t6_alu_op", op_seen[i], 2'b11);
    applyStimulus(16'hF0F0, 16'h0F0F, 0, 0, 2'b01, 16'h0000, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < NIBBLES; i++) checkOutput("t7_alu_op", op_seen[i], 2'b01);

    // Abort during the second RUN cycle.
    @(negedge clk);
    in_a = 16'h1111; in_b = 16'h2222; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_req_ready", req_ready, 1);
    checkOutput("abort_alu_a", alu_a, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    checkOutput("abort_no_valid", pulses, 0);
    applyStimulus(16'h1111, 16'h2222, 0, 0, 2'b00, 16'h3333, 0, 0, 0, 0, 0, 1);

    // Reset asserted while holding a result.
    applyStimulus(16'h0001, 16'h0001, 0, 0, 2'b00, 16'h0002, 0, 0, 0, 2, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_done_req_ready", req_ready, 1);
    checkOutput("rst_done_res_valid", res_valid, 0);
    checkOutput("rst_done_res_s", res_s, 0);
    checkOutput("rst_done_flags", {res_c, res_zero, res_overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", req_ready, 1);

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
